// File: rtl/id_ex_stage_if.sv
// Bundle of the ID/EX stage signals. The slave modport is the stage itself.
// The master modport is the surrounding pipeline that drives it.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dest_addr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [2:0]        id_alu_sel;
  logic              id_alu_src;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              exm_reg_write;
  logic [REG_AW-1:0] exm_dest_addr;
  logic [DATA_W-1:0] exm_result;
  logic              wb_reg_write;
  logic [REG_AW-1:0] wb_dest_addr;
  logic [DATA_W-1:0] wb_result;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_a;
  logic [DATA_W-1:0] ex_alu_b;
  logic [2:0]        ex_alu_sel;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_dest_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              load_use_stall;

  modport master (
    output stall, flush, id_valid, id_rs_addr, id_rt_addr, id_uses_rt,
           id_dest_addr, id_rs_data, id_rt_data, id_imm, id_alu_sel,
           id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           exm_reg_write, exm_dest_addr, exm_result,
           wb_reg_write, wb_dest_addr, wb_result,
    input  ex_valid, ex_alu_a, ex_alu_b, ex_alu_sel, ex_store_data,
           ex_dest_addr, ex_reg_write, ex_mem_read, ex_mem_write,
           load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_addr, id_rt_addr, id_uses_rt,
           id_dest_addr, id_rs_data, id_rt_data, id_imm, id_alu_sel,
           id_alu_src, id_reg_write, id_mem_read, id_mem_write,
           exm_reg_write, exm_dest_addr, exm_result,
           wb_reg_write, wb_dest_addr, wb_result,
    output ex_valid, ex_alu_a, ex_alu_b, ex_alu_sel, ex_store_data,
           ex_dest_addr, ex_reg_write, ex_mem_read, ex_mem_write,
           load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS32 ID/EX pipeline register with EX operand forwarding and load-use bubbles.
// Priority on each edge: reset, flush, stall (hold + operand refresh), load-use bubble, capture.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  logic              r_valid;
  logic [REG_AW-1:0] r_rs_addr;
  logic [REG_AW-1:0] r_rt_addr;
  logic [REG_AW-1:0] r_dest_addr;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [2:0]        r_alu_sel;
  logic              r_alu_src;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;

  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;
  logic [DATA_W-1:0] w_cap_rs;
  logic [DATA_W-1:0] w_cap_rt;
  logic              w_hazard_match;
  logic              w_load_use;

  // Register 0 is hardwired, so it never takes a forwarded value.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (r_rs_addr != '0) begin
      if (bus.exm_reg_write && (bus.exm_dest_addr == r_rs_addr))
        w_fwd_rs = bus.exm_result;
      else if (bus.wb_reg_write && (bus.wb_dest_addr == r_rs_addr))
        w_fwd_rs = bus.wb_result;
    end
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (r_rt_addr != '0) begin
      if (bus.exm_reg_write && (bus.exm_dest_addr == r_rt_addr))
        w_fwd_rt = bus.exm_result;
      else if (bus.wb_reg_write && (bus.wb_dest_addr == r_rt_addr))
        w_fwd_rt = bus.wb_result;
    end
  end

  // Writeback in the same cycle as decode has not reached the register file yet.
  always_comb begin
    w_cap_rs = bus.id_rs_data;
    w_cap_rt = bus.id_rt_data;
    if (bus.wb_reg_write && (bus.wb_dest_addr != '0)) begin
      if (bus.wb_dest_addr == bus.id_rs_addr)
        w_cap_rs = bus.wb_result;
      if (bus.wb_dest_addr == bus.id_rt_addr)
        w_cap_rt = bus.wb_result;
    end
  end

  assign w_hazard_match = (r_dest_addr == bus.id_rs_addr) ||
                          (bus.id_uses_rt && (r_dest_addr == bus.id_rt_addr));

  assign w_load_use = r_valid && r_mem_read && (r_dest_addr != '0) &&
                      bus.id_valid && w_hazard_match && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_dest_addr <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_alu_sel   <= 3'b000;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (bus.flush || (!bus.stall && w_load_use)) begin
      r_valid     <= 1'b0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_dest_addr <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_alu_sel   <= 3'b000;
      r_alu_src   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (bus.stall) begin
      // Keep the producer's value even after it retires past WB.
      r_rs_data <= w_fwd_rs;
      r_rt_data <= w_fwd_rt;
    end else begin
      r_valid     <= bus.id_valid;
      r_rs_addr   <= bus.id_rs_addr;
      r_rt_addr   <= bus.id_rt_addr;
      r_dest_addr <= bus.id_dest_addr;
      r_rs_data   <= w_cap_rs;
      r_rt_data   <= w_cap_rt;
      r_imm       <= bus.id_imm;
      r_alu_sel   <= bus.id_alu_sel;
      r_alu_src   <= bus.id_alu_src;
      r_reg_write <= bus.id_valid & bus.id_reg_write;
      r_mem_read  <= bus.id_valid & bus.id_mem_read;
      r_mem_write <= bus.id_valid & bus.id_mem_write;
    end
  end

  assign bus.ex_valid       = r_valid;
  assign bus.ex_alu_a       = w_fwd_rs;
  assign bus.ex_alu_b       = r_alu_src ? r_imm : w_fwd_rt;
  assign bus.ex_alu_sel     = r_alu_sel;
  assign bus.ex_store_data  = w_fwd_rt;
  assign bus.ex_dest_addr   = r_dest_addr;
  assign bus.ex_reg_write   = r_valid & r_reg_write;
  assign bus.ex_mem_read    = r_valid & r_mem_read;
  assign bus.ex_mem_write   = r_valid & r_mem_write;
  assign bus.load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, forwarding, immediate select,
// load-use bubbles, flush/stall priority and stall-time operand refresh.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic clearForwarding();
    bus.exm_reg_write = 1'b0;
    bus.exm_dest_addr = '0;
    bus.exm_result    = '0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_dest_addr  = '0;
    bus.wb_result     = '0;
  endtask

  task automatic applyStimulus(
    input logic        valid,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic        usesRt,
    input logic [4:0]  dest,
    input logic [31:0] rsData,
    input logic [31:0] rtData,
    input logic [31:0] imm,
    input logic [2:0]  sel,
    input logic        src,
    input logic        rw,
    input logic        mr,
    input logic        mw
  );
    bus.id_valid     = valid;
    bus.id_rs_addr   = rs;
    bus.id_rt_addr   = rt;
    bus.id_uses_rt   = usesRt;
    bus.id_dest_addr = dest;
    bus.id_rs_data   = rsData;
    bus.id_rt_data   = rtData;
    bus.id_imm       = imm;
    bus.id_alu_sel   = sel;
    bus.id_alu_src   = src;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    bus.stall  = 1'b0;
    bus.flush  = 1'b0;
    clearForwarding();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    rst = 1'b1;
    stepClock();
    stepClock();
    rst = 1'b0;
    checkOutput("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("rst_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    checkOutput("rst_lus", {31'd0, bus.load_use_stall}, 32'd0);

    // Plain add, then reset mid-stream
    applyStimulus(1, 1, 2, 1, 3, 32'h10, 32'h20, 0, 3'b000, 0, 1, 0, 0);
    stepClock();
    checkOutput("add_valid", {31'd0, bus.ex_valid}, 32'd1);
    checkOutput("add_a", bus.ex_alu_a, 32'h10);
    checkOutput("add_b", bus.ex_alu_b, 32'h20);
    checkOutput("add_rw", {31'd0, bus.ex_reg_write}, 32'd1);
    checkOutput("add_dest", {27'd0, bus.ex_dest_addr}, 32'd3);
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
    checkOutput("rst2_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("rst2_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    checkOutput("rst2_a", bus.ex_alu_a, 32'd0);
    checkOutput("rst2_dest", {27'd0, bus.ex_dest_addr}, 32'd0);
    checkOutput("rst2_lus", {31'd0, bus.load_use_stall}, 32'd0);

    // EX/MEM versus MEM/WB forwarding priority
    applyStimulus(1, 3, 4, 1, 9, 32'h11, 32'h22, 0, 3'b001, 0, 1, 0, 0);
    stepClock();
    bus.exm_reg_write = 1'b1; bus.exm_dest_addr = 5'd3; bus.exm_result = 32'hAA;
    bus.wb_reg_write  = 1'b1; bus.wb_dest_addr  = 5'd3; bus.wb_result  = 32'h55;
    #1;
    checkOutput("fwd_exm", bus.ex_alu_a, 32'hAA);
    checkOutput("fwd_sel", {29'd0, bus.ex_alu_sel}, 32'd1);
    bus.exm_dest_addr = 5'd4;
    #1;
    checkOutput("fwd_wb", bus.ex_alu_a, 32'h55);
    checkOutput("fwd_exm_rt", bus.ex_alu_b, 32'hAA);
    clearForwarding();
    #1;
    checkOutput("fwd_none", bus.ex_alu_a, 32'h11);

    // Register 0 never forwards
    applyStimulus(1, 0, 4, 1, 9, 32'h77, 32'h22, 0, 3'b000, 0, 1, 0, 0);
    stepClock();
    bus.exm_reg_write = 1'b1; bus.exm_dest_addr = 5'd0; bus.exm_result = 32'hAA;
    bus.wb_reg_write  = 1'b1; bus.wb_dest_addr  = 5'd0; bus.wb_result  = 32'h55;
    #1;
    checkOutput("zero_a", bus.ex_alu_a, 32'h77);
    clearForwarding();

    // Immediate select
    applyStimulus(1, 1, 6, 1, 10, 32'h1, 32'h66, 32'hFFFF_FFFC, 3'b101, 1, 1, 0, 0);
    stepClock();
    checkOutput("imm_b", bus.ex_alu_b, 32'hFFFF_FFFC);
    checkOutput("imm_sel", {29'd0, bus.ex_alu_sel}, 32'd5);
    checkOutput("imm_store", bus.ex_store_data, 32'h66);
    bus.exm_reg_write = 1'b1; bus.exm_dest_addr = 5'd6; bus.exm_result = 32'hCAFE;
    #1;
    checkOutput("imm_store_fwd", bus.ex_store_data, 32'hCAFE);
    checkOutput("imm_b_keep", bus.ex_alu_b, 32'hFFFF_FFFC);
    clearForwarding();

    // Load-use on rt
    applyStimulus(1, 1, 0, 0, 8, 32'h100, 0, 32'h4, 3'b000, 1, 1, 1, 0);
    stepClock();
    checkOutput("lw_mr", {31'd0, bus.ex_mem_read}, 32'd1);
    applyStimulus(1, 2, 8, 1, 11, 32'h2, 32'h3, 0, 3'b000, 0, 1, 0, 0);
    #1;
    checkOutput("lu_rt", {31'd0, bus.load_use_stall}, 32'd1);
    bus.flush = 1'b1;
    #1;
    checkOutput("lu_flush_mask", {31'd0, bus.load_use_stall}, 32'd0);
    bus.flush = 1'b0;
    bus.stall = 1'b1;
    #1;
    checkOutput("lu_stall_rep", {31'd0, bus.load_use_stall}, 32'd1);
    stepClock();
    checkOutput("lu_hold_valid", {31'd0, bus.ex_valid}, 32'd1);
    checkOutput("lu_hold_mr", {31'd0, bus.ex_mem_read}, 32'd1);
    checkOutput("lu_hold_dest", {27'd0, bus.ex_dest_addr}, 32'd8);
    bus.stall = 1'b0;
    stepClock();
    checkOutput("lu_bub_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("lu_bub_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    checkOutput("lu_bub_dest", {27'd0, bus.ex_dest_addr}, 32'd0);

    // No hazard when rt is not read
    applyStimulus(1, 1, 0, 0, 8, 32'h100, 0, 32'h4, 3'b000, 1, 1, 1, 0);
    stepClock();
    applyStimulus(1, 9, 8, 0, 11, 32'h2, 32'h3, 0, 3'b000, 0, 1, 0, 0);
    #1;
    checkOutput("lu_no_rt", {31'd0, bus.load_use_stall}, 32'd0);
    bus.id_rs_addr = 5'd8;
    #1;
    checkOutput("lu_rs", {31'd0, bus.load_use_stall}, 32'd1);
    bus.id_valid = 1'b0;
    #1;
    checkOutput("lu_id_invalid", {31'd0, bus.load_use_stall}, 32'd0);

    // Flush beats stall
    applyStimulus(1, 4, 5, 1, 0, 32'h40, 32'h50, 32'h8, 3'b000, 1, 0, 0, 1);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    stepClock();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    checkOutput("fs_valid", {31'd0, bus.ex_valid}, 32'd0);
    checkOutput("fs_mw", {31'd0, bus.ex_mem_write}, 32'd0);
    stepClock();
    checkOutput("sw_mw", {31'd0, bus.ex_mem_write}, 32'd1);
    checkOutput("sw_rw", {31'd0, bus.ex_reg_write}, 32'd0);

    // Stall refresh keeps a value that retires during the stall
    applyStimulus(1, 5, 0, 0, 12, 32'h0, 32'h0, 0, 3'b010, 0, 1, 0, 0);
    stepClock();
    bus.stall = 1'b1;
    applyStimulus(1, 1, 2, 1, 13, 32'h999, 32'h888, 0, 3'b011, 0, 1, 0, 0);
    bus.wb_reg_write = 1'b1; bus.wb_dest_addr = 5'd5; bus.wb_result = 32'h1234;
    #1;
    checkOutput("st_fwd", bus.ex_alu_a, 32'h1234);
    stepClock();
    clearForwarding();
    stepClock();
    stepClock();
    bus.stall = 1'b0;
    #1;
    checkOutput("st_a", bus.ex_alu_a, 32'h1234);
    checkOutput("st_dest", {27'd0, bus.ex_dest_addr}, 32'd12);
    checkOutput("st_sel", {29'd0, bus.ex_alu_sel}, 32'd2);

    // Decode-time bypass from writeback
    applyStimulus(1, 7, 7, 1, 14, 32'h1, 32'h2, 0, 3'b000, 0, 1, 0, 0);
    bus.wb_reg_write = 1'b1; bus.wb_dest_addr = 5'd7; bus.wb_result = 32'hBEEF;
    stepClock();
    clearForwarding();
    #1;
    checkOutput("byp_a", bus.ex_alu_a, 32'hBEEF);
    checkOutput("byp_store", bus.ex_store_data, 32'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-forwarding stage of the MIPS32 pipeline. It sits directly upstream of the EX-stage ALU and drives its operands and 3-bit operation select. It also detects load-use hazards and inserts bubbles into EX. Stall, flush and hazard bubbles are all handled inside this block.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  external hold of ID/EX (e.g. downstream busy)
flush  in  1  squash the instruction entering EX (branch taken)
id_valid  in  1  ID holds a real instruction
id_rs_addr  in  REG_AW  source register A
id_rt_addr  in  REG_AW  source register B
id_uses_rt  in  1  instruction reads rt (R-type, stores, branches)
id_dest_addr  in  REG_AW  resolved destination register
id_rs_data  in  DATA_W  register-file value for rs
id_rt_data  in  DATA_W  register-file value for rt
id_imm  in  DATA_W  extended immediate
id_alu_sel  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
id_alu_src  in  1  1 = ALU B takes the immediate
id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
exm_reg_write  in  1  EX/MEM writes a register
exm_dest_addr  in  REG_AW  EX/MEM destination
exm_result  in  DATA_W  EX/MEM ALU result
wb_reg_write  in  1  MEM/WB writes a register
wb_dest_addr  in  REG_AW  MEM/WB destination
wb_result  in  DATA_W  MEM/WB writeback value
ex_valid  out  1  EX holds a real instruction
ex_alu_a  out  DATA_W  forwarded ALU operand A
ex_alu_b  out  DATA_W  forwarded rt or immediate
ex_alu_sel  out  3  registered id_alu_sel
ex_store_data  out  DATA_W  forwarded rt, for stores
ex_dest_addr  out  REG_AW  registered destination
ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered controls, gated by valid
load_use_stall  out  1  combinational request to hold PC and IF/ID

Behaviour:
- Reset: every register clears to 0. ex_valid=0, all controls 0, alu_sel=000, addresses 0, stored data 0. load_use_stall is therefore 0.
- Per-edge update, priority order: rst > flush > stall > load_use_stall > load.
  - flush: insert a bubble.
  - stall: hold every field; rs/rt data registers are refreshed (see below).
  - load_use_stall: insert a bubble.
  - Otherwise: capture the ID fields.
- Bubble: ex_valid=0. reg_write, mem_read and mem_write are 0. Addresses, data and alu_sel are 0.
- Control gating: ex_reg_write, ex_mem_read and ex_mem_write are never 1 while ex_valid=0.
- ID-side bypass on capture: if wb_reg_write=1, wb_dest_addr≠0 and wb_dest_addr equals id_rs_addr, capture wb_result instead of id_rs_data. The same rule applies independently to rt.
- EX forwarding (combinational on the registered rs/rt addresses), per operand:
  - Source address 0 always uses the stored value.
  - Else if exm_reg_write=1 and exm_dest_addr equals the source address, use exm_result.
  - Else if wb_reg_write=1 and wb_dest_addr equals the source address, use wb_result.
  - Else use the stored value.
  - EX/MEM beats MEM/WB when both match.
- Operand outputs:
  - ex_alu_a = forwarded rs.
  - ex_store_data = forwarded rt.
  - ex_alu_b = id_imm (registered) when the registered alu_src=1, else forwarded rt.
- Stall refresh: while stall=1, the stored rs/rt data registers load their current forwarded values. This keeps a producer's result after that producer retires past WB during a multi-cycle stall.
- Load-use detection, combinational: load_use_stall=1 when all of the following hold:
  - ex_valid=1, ex_mem_read=1, ex_dest_addr≠0, id_valid=1;
  - and either ex_dest_addr equals id_rs_addr, or (id_uses_rt=1 and ex_dest_addr equals id_rt_addr).
- Masking: load_use_stall is forced to 0 while flush=1. While stall=1 it is still reported, but stall wins and the register holds rather than bubbling.
- Simultaneous flush and stall: flush wins and a bubble is inserted.
- Latency: ID-to-EX is one cycle. Forwarding muxes add zero cycles.

Test Plan:
- Reset mid-stream: load an add with valid=1, then assert rst for 1 cycle → next edge ex_valid=0, all controls 0, ex_alu_a=0, load_use_stall=0.
- EX/MEM forward: rs=3, exm_reg_write=1, exm_dest=3, exm_result=0x0000_00AA, wb_dest=3, wb_result=0x55 → ex_alu_a=0xAA (EX/MEM priority). Repeat with exm_dest=0 and rs=0 → stored value passes through.
- Immediate select: id_alu_src=1, id_imm=0xFFFF_FFFC, id_alu_sel=101 → ex_alu_b=0xFFFF_FFFC, ex_alu_sel=101, and ex_store_data still equals forwarded rt.
- Load-use: EX holds lw with dest=8; ID holds add with rt=8 and id_uses_rt=1 → load_use_stall=1, next edge ex_valid=0. Repeat with id_uses_rt=0 and rs≠8 → load_use_stall=0.
- Flush with stall: flush=1 and stall=1 in the same cycle, with ID holding sw → next edge ex_valid=0 and ex_mem_write=0.
- Stall refresh: hold stall=1 for 3 cycles while wb writes reg 5 = 0x1234 once (rs=5) → after release ex_alu_a=0x1234 with no WB match present.
